// File: rtl/nn_pkg.sv
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and sizing helpers for the digit-inference slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2
  } nn_state_t;

  localparam int c_num_pixels = 784;
  localparam int c_out_data   = 10;
  localparam int c_out_width  = $clog2(c_out_data);

  function automatic int pix_cnt_width(input int num_pixels);
    return $clog2(num_pixels + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nn_infer_ctrl.sv
// ============================================================================
// Module      : nn_infer_ctrl
// Description : Sequences one image through nn_memory and the net core and
//               latches the resulting classification.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_infer_ctrl
  import nn_pkg::*;
#(
  parameter int dataWidth  = 16,
  parameter int NUM_PIXELS = c_num_pixels,
  parameter int outData    = c_out_data,
  parameter int TIMEOUT    = 4096,
  localparam int outWidth  = $clog2(outData),
  localparam int PIX_W     = pix_cnt_width(NUM_PIXELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                mem_ren,
  input  logic                mem_valid,
  input  logic                mem_last,
  input  logic                net_out_valid,
  input  logic [outWidth-1:0] net_out_data,
  output logic                result_valid,
  output logic [outWidth-1:0] result,
  output logic [PIX_W-1:0]    pix_cnt,
  output logic                err_len,
  output logic                err_timeout
);

  localparam int               c_tw   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_tw-1:0]  c_tmax = c_tw'(TIMEOUT - 1);
  localparam logic [PIX_W-1:0] c_npix = PIX_W'(NUM_PIXELS);

  // Pixel words never pass through this block; the width only has to be sane.
  if (dataWidth < 1) begin : g_bad_data_width
    localparam int c_bad = 1;
  end

  nn_state_t           r_state,  w_state_nxt;
  logic                r_mem_ren, w_mem_ren_nxt;
  logic [PIX_W-1:0]    r_pix_cnt, w_pix_cnt_nxt, w_pix_inc;
  logic [c_tw-1:0]     r_tcnt,    w_tcnt_nxt;
  logic                r_err_len, w_err_len_nxt;
  logic [outWidth-1:0] r_result,  w_result_nxt;
  logic                r_result_valid, w_result_valid_nxt;
  logic                r_err_timeout,  w_err_timeout_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_mem_ren      <= 1'b0;
      r_pix_cnt      <= '0;
      r_tcnt         <= '0;
      r_err_len      <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_mem_ren      <= w_mem_ren_nxt;
      r_pix_cnt      <= w_pix_cnt_nxt;
      r_tcnt         <= w_tcnt_nxt;
      r_err_len      <= w_err_len_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_err_timeout  <= w_err_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_mem_ren_nxt      = r_mem_ren;
    w_pix_cnt_nxt      = r_pix_cnt;
    w_tcnt_nxt         = r_tcnt;
    w_err_len_nxt      = r_err_len;
    w_result_nxt       = r_result;
    w_result_valid_nxt = 1'b0;
    w_err_timeout_nxt  = 1'b0;
    w_pix_inc          = r_pix_cnt + 1'b1;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = STREAM;
          w_mem_ren_nxt = 1'b1;
          w_pix_cnt_nxt = '0;
          w_err_len_nxt = 1'b0;
        end
      end
      STREAM: begin
        if (mem_valid) begin
          w_pix_cnt_nxt = w_pix_inc;
          // Either the marker or the hard cap ends the image; only both together is clean.
          if (mem_last || (w_pix_inc == c_npix)) begin
            w_mem_ren_nxt = 1'b0;
            w_state_nxt   = WAIT_RES;
            w_tcnt_nxt    = '0;
            w_err_len_nxt = !(mem_last && (w_pix_inc == c_npix));
          end
        end
      end
      WAIT_RES: begin
        if (net_out_valid) begin
          w_result_nxt       = net_out_data;
          w_result_valid_nxt = 1'b1;
          w_state_nxt        = IDLE;
        end else if (r_tcnt == c_tmax) begin
          w_err_timeout_nxt = 1'b1;
          w_state_nxt       = IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_mem_ren_nxt = 1'b0;
      end
    endcase
  end

  assign busy         = (r_state != IDLE);
  assign mem_ren      = r_mem_ren;
  assign pix_cnt      = r_pix_cnt;
  assign err_len      = r_err_len;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign err_timeout  = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_nn_infer_ctrl.sv
// ============================================================================
// Module      : tb_nn_infer_ctrl
// Description : Randomized self-checking bench for nn_infer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_infer_ctrl;

  localparam int NP = 784;
  localparam int TO = 64;
  localparam int OW = 4;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_valid = 1'b0;
  logic          mem_last = 1'b0;
  logic          net_out_valid = 1'b0;
  logic [OW-1:0] net_out_data = '0;
  logic          busy, mem_ren, result_valid, err_len, err_timeout;
  logic [OW-1:0] result;
  logic [PW-1:0] pix_cnt;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [OW-1:0] exp_result = '0;

  nn_infer_ctrl #(
    .dataWidth (16),
    .NUM_PIXELS(NP),
    .outData   (10),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .mem_ren      (mem_ren),
    .mem_valid    (mem_valid),
    .mem_last     (mem_last),
    .net_out_valid(net_out_valid),
    .net_out_data (net_out_data),
    .result_valid (result_valid),
    .result       (result),
    .pix_cnt      (pix_cnt),
    .err_len      (err_len),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One inference. last_at: beat carrying mem_last (0 = never). net_delay: WAIT_RES
  // cycle on which the net answers (-1 = never). abort_at > 0: reset after that many beats.
  task automatic run_image(input int last_at, input int net_delay, input logic [OW-1:0] digit,
                           input bit gaps, input bit noisy, input int abort_at);
    int exp_end;
    bit exp_err;
    int sent;
    int guard;
    bit v;
    exp_end = (last_at >= 1 && last_at <= NP) ? last_at : NP;
    exp_err = (last_at != NP);

    start = 1'b1;
    step();
    start = noisy;
    check("start_busy", busy, 1);
    check("start_ren", mem_ren, 1);
    check("start_pix", pix_cnt, 0);
    check("start_errlen", err_len, 0);

    sent  = 0;
    guard = 0;
    while (sent < exp_end && guard < 8 * NP) begin
      if (abort_at > 0 && sent == abort_at) break;
      v             = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_valid     = v;
      mem_last      = v ? (sent + 1 == last_at) : 1'($urandom_range(0, 1));
      net_out_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      net_out_data  = OW'($urandom_range(0, 9));
      step();
      guard++;
      if (v) sent++;
      check("stream_rv", result_valid, 0);
      if (sent < exp_end) begin
        check("stream_ren", mem_ren, 1);
        check("stream_pix", pix_cnt, sent);
      end
    end
    mem_valid     = 1'b0;
    mem_last      = 1'b0;
    net_out_valid = 1'b0;

    if (abort_at > 0) begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_ren", mem_ren, 0);
      check("rst_busy", busy, 0);
      check("rst_pix", pix_cnt, 0);
      check("rst_result", result, 0);
      exp_result = '0;
      start = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_busy", busy, 0);
      return;
    end

    check("stream_beats", sent, exp_end);
    check("end_ren", mem_ren, 0);
    check("end_pix", pix_cnt, exp_end);
    check("end_errlen", err_len, exp_err);
    check("end_busy", busy, 1);
    start = 1'b0;

    for (int w = 0; w < TO + 8; w++) begin
      mem_valid     = (w < 3);
      mem_last      = 1'b0;
      net_out_valid = (w == net_delay);
      net_out_data  = net_out_valid ? digit : OW'($urandom_range(0, 15));
      step();
      if (w == net_delay) begin
        check("res_valid", result_valid, 1);
        check("res_value", result, digit);
        check("res_busy", busy, 0);
        check("res_to", err_timeout, 0);
        exp_result = digit;
        break;
      end else if (w == TO - 1) begin
        check("to_pulse", err_timeout, 1);
        check("to_rv", result_valid, 0);
        check("to_busy", busy, 0);
        check("to_result", result, exp_result);
        break;
      end else begin
        check("wait_busy", busy, 1);
        check("wait_rv", result_valid, 0);
        check("wait_to", err_timeout, 0);
        check("wait_pix", pix_cnt, exp_end);
      end
    end
    mem_valid     = 1'b0;
    net_out_valid = 1'b0;
    step();
    check("idle_rv", result_valid, 0);
    check("idle_to", err_timeout, 0);
    check("idle_result", result, exp_result);
    check("idle_errlen", err_len, exp_err);
    check("idle_busy", busy, 0);
    check("idle_ren", mem_ren, 0);
  endtask

  initial begin
    int k;
    int last_at;
    int dly;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0", busy, 0);
    check("rst_ren0", mem_ren, 0);
    check("rst_pix0", pix_cnt, 0);
    check("rst_errlen0", err_len, 0);
    check("rst_result0", result, 0);
    check("rst_rv0", result_valid, 0);
    check("rst_to0", err_timeout, 0);
    rst_n = 1'b1;
    step();

    run_image(NP, 30, 4'd7, 1'b0, 1'b0, 0);
    run_image(500, int'($urandom_range(0, 40)), OW'($urandom_range(0, 9)), 1'b1, 1'b0, 0);
    run_image(0, 10, 4'd3, 1'b0, 1'b0, 0);
    run_image(NP, -1, 4'd5, 1'b0, 1'b0, 0);
    run_image(NP, TO - 1, 4'd9, 1'b1, 1'b0, 0);
    run_image(100, 5, 4'd2, 1'b0, 1'b1, 0);
    run_image(NP, 0, 4'd4, 1'b0, 1'b0, 0);
    run_image(NP, 0, 4'd0, 1'b0, 1'b0, 300);
    run_image(NP, 12, 4'd6, 1'b1, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      k = int'($urandom_range(0, 3));
      case (k)
        0:       last_at = int'($urandom_range(1, NP));
        1:       last_at = NP;
        2:       last_at = 0;
        default: last_at = NP + 5;
      endcase
      dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO + 4));
      run_image(last_at, dly, OW'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete t=%0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
